// File: rtl/shift32_reg_unit.sv
// Registered 32-bit logical shifter: five-stage left and right barrel networks,
// a direction mux, a range check on the upper shift bits, and a one-cycle output register.
module shift32_reg_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR,
  input  logic        EN,
  output logic [31:0] Y,
  output logic        VALID
);

  logic [31:0] leftS1, leftS2, leftS4, leftS8, leftS16;
  logic [31:0] rightS1, rightS2, rightS4, rightS8, rightS16;
  logic        outOfRange;
  logic [31:0] shiftResult;

  // Left network: each stage shifts by a fixed power of two when its S bit is set.
  always_comb begin
    leftS1  = S[0] ? {D[30:0], 1'b0}         : D;
    leftS2  = S[1] ? {leftS1[29:0], 2'b0}    : leftS1;
    leftS4  = S[2] ? {leftS2[27:0], 4'b0}    : leftS2;
    leftS8  = S[3] ? {leftS4[23:0], 8'b0}    : leftS4;
    leftS16 = S[4] ? {leftS8[15:0], 16'b0}   : leftS8;
  end

  // Right network is logical only; vacated MSBs fill with zero.
  always_comb begin
    rightS1  = S[0] ? {1'b0, D[31:1]}         : D;
    rightS2  = S[1] ? {2'b0, rightS1[31:2]}   : rightS1;
    rightS4  = S[2] ? {4'b0, rightS2[31:4]}   : rightS2;
    rightS8  = S[3] ? {8'b0, rightS4[31:8]}   : rightS4;
    rightS16 = S[4] ? {16'b0, rightS8[31:16]} : rightS8;
  end

  // Any amount of 32 or more flushes every bit out, so the upper S bits force zero.
  assign outOfRange = |S[31:5];

  always_comb begin
    shiftResult = 32'h0;
    if (!outOfRange) begin
      shiftResult = LnR ? leftS16 : rightS16;
    end
  end

  // VALID is a one-cycle strobe: high in the cycle after an EN=1 capture, with no
  // ready/backpressure; EN=0 holds Y and drops VALID.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Y     <= 32'h0;
      VALID <= 1'b0;
    end else begin
      VALID <= EN;
      if (EN) begin
        Y <= shiftResult;
      end
    end
  end

endmodule

// File: tb/tb_shift32_reg_unit.sv
// Self-checking bench for shift32_reg_unit: directed cases plus randomized sweeps
// compared against a plain-arithmetic shift model and an expected-result queue.
module tb_shift32_reg_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] D;
  logic [31:0] S;
  logic        LnR;
  logic        EN;
  logic [31:0] Y;
  logic        VALID;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] yModel;

  shift32_reg_unit dut (
    .CLK(CLK),
    .RST(RST),
    .D(D),
    .S(S),
    .LnR(LnR),
    .EN(EN),
    .Y(Y),
    .VALID(VALID)
  );

  // Clock and reset defaults
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [31:0] s,
                                           input logic lnr);
    longint unsigned wide;
    if (s >= 32) return 32'h0;
    if (lnr) begin
      wide = longint'(d) * (64'd1 << s);
      return wide[31:0];
    end
    return d / (32'd1 << s);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    if (obs !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then check just after the rising edge.
  task automatic applyOp(input string tag, input logic [31:0] d, input logic [31:0] s,
                         input logic lnr, input logic en);
    @(negedge CLK);
    D = d; S = s; LnR = lnr; EN = en;
    if (en) expQ.push_back(refShift(d, s, lnr));
    @(posedge CLK);
    #1;
    if (en) yModel = expQ.pop_front();
    checkVal({tag, "_y"}, Y, yModel);
    checkVal({tag, "_valid"}, {31'b0, VALID}, {31'b0, en});
  endtask

  initial begin
    RST = 1'b0; D = 32'hFFFF_FFFF; S = 32'd1; LnR = 1'b1; EN = 1'b1;
    yModel = 32'h0;

    // Reset held with EN=1 must keep outputs at zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checkVal("rst_y", Y, 32'h0);
      checkVal("rst_valid", {31'b0, VALID}, 32'h0);
    end
    @(negedge CLK);
    EN = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    checkVal("post_rst_y", Y, 32'h0);
    checkVal("post_rst_valid", {31'b0, VALID}, 32'h0);

    // Basic and multi-bit shifts
    applyOp("l1_64", 32'd64, 32'd1, 1'b1, 1'b1);
    checkVal("l1_64_const", Y, 32'd128);
    applyOp("r1_64", 32'd64, 32'd1, 1'b0, 1'b1);
    checkVal("r1_64_const", Y, 32'd32);
    applyOp("l8_100", 32'd100, 32'd8, 1'b1, 1'b1);
    checkVal("l8_100_const", Y, 32'd25600);
    applyOp("r8_100", 32'd100, 32'd8, 1'b0, 1'b1);
    applyOp("l2_40", 32'd40, 32'd2, 1'b1, 1'b1);
    applyOp("r2_40", 32'd40, 32'd2, 1'b0, 1'b1);
    checkVal("r2_40_const", Y, 32'd10);
    applyOp("l20_1", 32'd1, 32'd20, 1'b1, 1'b1);
    checkVal("l20_1_const", Y, 32'd1048576);
    applyOp("r20_1", 32'd1, 32'd20, 1'b0, 1'b1);

    // Boundaries
    applyOp("l0_7", 32'd7, 32'd0, 1'b1, 1'b1);
    checkVal("l0_7_const", Y, 32'd7);
    applyOp("r0_7", 32'd7, 32'd0, 1'b0, 1'b1);
    applyOp("l31", 32'h8000_0001, 32'd31, 1'b1, 1'b1);
    checkVal("l31_const", Y, 32'h8000_0000);
    applyOp("r31", 32'h8000_0001, 32'd31, 1'b0, 1'b1);
    checkVal("r31_const", Y, 32'd1);
    applyOp("l32", 32'd7, 32'd32, 1'b1, 1'b1);
    applyOp("r32", 32'd7, 32'd32, 1'b0, 1'b1);
    applyOp("l100", 32'd7, 32'd100, 1'b1, 1'b1);
    applyOp("r100", 32'd7, 32'd100, 1'b0, 1'b1);
    applyOp("lhigh", 32'd1, 32'h8000_0001, 1'b1, 1'b1);
    checkVal("lhigh_const", Y, 32'h0);
    applyOp("rhigh", 32'd1, 32'h8000_0001, 1'b0, 1'b1);

    // Enable and hold
    applyOp("hold_cap", 32'd64, 32'd1, 1'b1, 1'b1);
    applyOp("hold_a", 32'h1234_5678, 32'd3, 1'b0, 1'b0);
    applyOp("hold_b", 32'hDEAD_BEEF, 32'd9, 1'b1, 1'b0);
    checkVal("hold_const", Y, 32'd128);
    applyOp("hold_rel", 32'd100, 32'd1, 1'b1, 1'b1);
    checkVal("hold_rel_const", Y, 32'd200);

    // Reset pulse between edges while back-to-back captures are in flight
    applyOp("b2b_a", 32'h0000_00F0, 32'd4, 1'b1, 1'b1);
    @(negedge CLK);
    D = 32'hAAAA_5555; S = 32'd2; LnR = 1'b0; EN = 1'b1;
    #1 RST = 1'b0;
    #1;
    checkVal("midrst_y", Y, 32'h0);
    checkVal("midrst_valid", {31'b0, VALID}, 32'h0);
    @(posedge CLK); #1;
    checkVal("midrst_edge_y", Y, 32'h0);
    checkVal("midrst_edge_valid", {31'b0, VALID}, 32'h0);
    @(negedge CLK);
    EN = 1'b0;
    RST = 1'b1;
    yModel = 32'h0;
    @(posedge CLK); #1;
    checkVal("midrst_after_y", Y, 32'h0);
    checkVal("midrst_after_valid", {31'b0, VALID}, 32'h0);

    // Sweep all amounts 0..40 in both directions with random operands
    for (int dir = 0; dir < 2; dir++) begin
      for (int s = 0; s <= 40; s++) begin
        applyOp(dir ? "sweep_l" : "sweep_r", $urandom, 32'(s), 1'(dir), 1'b1);
      end
    end

    // Random mix including random enable and full-range amounts
    for (int i = 0; i < 200; i++) begin
      logic [31:0] sRand;
      sRand = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 35));
      applyOp("rand", $urandom, sRand, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
